// File: rtl/flag_stack.sv
// Condition-flag register with per-bit write enables and a LIFO save/restore stack.
// Define FLAG_STACK_ERR_EN to enable the sticky overflow/underflow error bits.
module flag_stack #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wen,
    input  logic [WIDTH-1:0] flags_in,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] flags_out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] wr_flags;
    logic             push_only;
    logic             pop_only;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign do_push   = push_only & ~full;
    assign do_pop    = pop_only & ~empty;
    assign wr_flags  = (flags_out & ~wen) | (flags_in & wen);

    // Loop-based lookup keeps the index width independent of CW.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) begin
                top = stack[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_out <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                flags_out <= top;
                count     <= count - CW'(1);
            end else if (!pop_only) begin
                flags_out <= wr_flags;
            end
            if (do_push) begin
                count <= count + CW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && count == CW'(i)) begin
                    stack[i] <= flags_out;
                end
            end
        end
    end

`ifdef FLAG_STACK_ERR_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = push_only & full;
    assign unf_set = pop_only & empty;

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= (ovf_err & ~err_clr) | ovf_set;
            unf_err <= (unf_err & ~err_clr) | unf_set;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf_err        = 1'b0;
    assign unf_err        = 1'b0;
`endif

endmodule
